// File: rtl/mult_coord_sequencer.sv
// Sequences the Mult_Coord datapath through a PE tile: K group (outer), activation (middle), weight (inner).
// Optional MULT_SEQ_PERF_EN adds saturating stall_cycles / issue_cycles counters.
module mult_coord_sequencer #(
  parameter int CNT_W = 16,
  parameter int KG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             new_layer,
  input  logic             flush,
  input  logic [CNT_W-1:0] num_act_vec,
  input  logic [CNT_W-1:0] num_wgt_vec,
  input  logic [KG_W-1:0]  num_k_grp,
  input  logic             iaram_valid,
  input  logic             weight_valid,
  input  logic             xbar_ready,
  output logic             stall,
  output logic             next_a,
  output logic             first_Ex_state_cycle,
  output logic             decode_restart,
  output logic             Layer_change_flag,
  output logic             K_changing,
  output logic [CNT_W-1:0] act_idx,
  output logic [CNT_W-1:0] wgt_idx,
  output logic [KG_W-1:0]  k_idx,
  output logic             busy,
  output logic             done
`ifdef MULT_SEQ_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      issue_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start, datapath held
  // LOAD  | restart decoders, clear indices
  // EXEC  | issue weight vectors against the stationary activation
  // KCHG  | step to next K group
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_KCHG, S_DONE} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] num_act_q, num_wgt_q;
  logic [KG_W-1:0]  num_k_q;
  logic             new_layer_q;
  logic             first_q, first_n;
  logic [CNT_W-1:0] act_n, wgt_n;
  logic [KG_W-1:0]  k_n;
  logic             load_cfg;
  logic             issue;
  logic             wgt_last, act_last, k_last;

  // flush gating here is what makes an abort win over a same-cycle issue
  assign issue    = (state_q == S_EXEC) & xbar_ready & iaram_valid & weight_valid & ~flush;
  assign wgt_last = (wgt_idx == num_wgt_q - CNT_W'(1));
  assign act_last = (act_idx == num_act_q - CNT_W'(1));
  assign k_last   = (k_idx == num_k_q - KG_W'(1));

  always_comb begin
    state_n              = state_q;
    act_n                = act_idx;
    wgt_n                = wgt_idx;
    k_n                  = k_idx;
    first_n              = first_q;
    load_cfg             = 1'b0;
    stall                = 1'b1;
    next_a               = 1'b0;
    first_Ex_state_cycle = 1'b0;
    decode_restart       = 1'b0;
    Layer_change_flag    = 1'b0;
    K_changing           = 1'b0;
    done                 = 1'b0;
    busy                 = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          load_cfg = 1'b1;
          if (num_act_vec == '0 || num_wgt_vec == '0 || num_k_grp == '0)
            state_n = S_DONE;
          else
            state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        decode_restart    = 1'b1;
        Layer_change_flag = new_layer_q;
        act_n             = '0;
        wgt_n             = '0;
        k_n               = '0;
        first_n           = 1'b1;
        state_n           = S_EXEC;
      end
      S_EXEC: begin
        stall                = ~issue;
        first_Ex_state_cycle = first_q;
        if (issue) begin
          if (wgt_last) begin
            next_a  = 1'b1;
            wgt_n   = '0;
            first_n = 1'b1;
            if (!act_last)
              act_n = act_idx + CNT_W'(1);
            else if (!k_last)
              state_n = S_KCHG;
            else
              state_n = S_DONE;
          end else begin
            wgt_n   = wgt_idx + CNT_W'(1);
            first_n = 1'b0;
          end
        end
      end
      S_KCHG: begin
        K_changing = 1'b1;
        k_n        = k_idx + KG_W'(1);
        act_n      = '0;
        first_n    = 1'b1;
        state_n    = S_EXEC;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) begin
      state_n = S_IDLE;
      act_n   = '0;
      wgt_n   = '0;
      k_n     = '0;
      first_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      act_idx <= '0;
      wgt_idx <= '0;
      k_idx   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_n;
      act_idx <= act_n;
      wgt_idx <= wgt_n;
      k_idx   <= k_n;
      first_q <= first_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_act_q   <= '0;
      num_wgt_q   <= '0;
      num_k_q     <= '0;
      new_layer_q <= 1'b0;
    end else if (load_cfg) begin
      num_act_q   <= num_act_vec;
      num_wgt_q   <= num_wgt_vec;
      num_k_q     <= num_k_grp;
      new_layer_q <= new_layer;
    end
  end

`ifdef MULT_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      issue_cycles <= '0;
    end else if (state_q == S_LOAD) begin
      stall_cycles <= '0;
      issue_cycles <= '0;
    end else if (state_q == S_EXEC) begin
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (issue && issue_cycles != '1)
        issue_cycles <= issue_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_coord_sequencer.sv
// Directed self-checking bench for mult_coord_sequencer; honours MULT_SEQ_PERF_EN when defined.
module tb_mult_coord_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, new_layer, flush;
  logic [15:0] num_act_vec, num_wgt_vec;
  logic [7:0]  num_k_grp;
  logic        iaram_valid, weight_valid, xbar_ready;
  logic        stall, next_a, first_Ex_state_cycle, decode_restart, Layer_change_flag, K_changing;
  logic [15:0] act_idx, wgt_idx;
  logic [7:0]  k_idx;
  logic        busy, done;
`ifdef MULT_SEQ_PERF_EN
  logic [31:0] stall_cycles, issue_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_coord_sequencer #(.CNT_W(16), .KG_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .new_layer(new_layer), .flush(flush),
    .num_act_vec(num_act_vec), .num_wgt_vec(num_wgt_vec), .num_k_grp(num_k_grp),
    .iaram_valid(iaram_valid), .weight_valid(weight_valid), .xbar_ready(xbar_ready),
    .stall(stall), .next_a(next_a), .first_Ex_state_cycle(first_Ex_state_cycle),
    .decode_restart(decode_restart), .Layer_change_flag(Layer_change_flag),
    .K_changing(K_changing), .act_idx(act_idx), .wgt_idx(wgt_idx), .k_idx(k_idx),
    .busy(busy), .done(done)
`ifdef MULT_SEQ_PERF_EN
    , .stall_cycles(stall_cycles), .issue_cycles(issue_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int a, input int w, input int k, input logic nl);
    num_act_vec = 16'(a);
    num_wgt_vec = 16'(w);
    num_k_grp   = 8'(k);
    new_layer   = nl;
    start       = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({stall, busy, done, next_a, first_Ex_state_cycle, decode_restart, Layer_change_flag, K_changing} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=10000000", {stall, busy, done, next_a, first_Ex_state_cycle, decode_restart, Layer_change_flag, K_changing});
    end
    n_checks++;
    if ({act_idx, wgt_idx, k_idx} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_indices got=%h exp=0", {act_idx, wgt_idx, k_idx});
    end
    tick();
    rst = 1'b0;
  endtask

  // A=2 W=3 K=1, always ready
  task automatic test_basic();
    tick();
    arm(2, 3, 1, 1'b0);
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if ({decode_restart, Layer_change_flag, stall, busy} !== 4'b1011) begin
      n_fail++;
      $display("FAIL basic_load got=%b exp=1011", {decode_restart, Layer_change_flag, stall, busy});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      n_checks++;
      if ({stall, next_a, first_Ex_state_cycle} !== {1'b0, (i % 3) == 2, (i % 3) == 0}) begin
        n_fail++;
        $display("FAIL basic_flags issue=%0d got=%b exp=%b", i + 1, {stall, next_a, first_Ex_state_cycle}, {1'b0, (i % 3) == 2, (i % 3) == 0});
      end
      n_checks++;
      if (wgt_idx !== 16'(i % 3) || act_idx !== 16'(i / 3)) begin
        n_fail++;
        $display("FAIL basic_idx issue=%0d got w=%0d a=%0d exp w=%0d a=%0d", i + 1, wgt_idx, act_idx, i % 3, i / 3);
      end
    end
    tick();
    #1;
    n_checks++;
    if (done !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_cycle8 got done=%b stall=%b exp 1 1", done, stall);
    end
    tick();
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  // A=1 W=2 K=3 with new_layer
  task automatic test_kgroups();
    int dr_cnt = 0, lcf_cnt = 0, lcf_dr = 0, kc_cnt = 0, kc_bad = 0, n_iss = 0, done_cnt = 0, done_cyc = -1;
    int kseq[8];
    int kexp[6] = '{0, 0, 1, 1, 2, 2};
    tick();
    arm(1, 2, 3, 1'b1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      start = 1'b0;
      #1;
      if (decode_restart) begin dr_cnt++; if (Layer_change_flag) lcf_dr++; end
      if (Layer_change_flag) lcf_cnt++;
      if (K_changing) begin kc_cnt++; if (stall !== 1'b1) kc_bad++; end
      if (busy && !stall) begin
        if (n_iss < 8) kseq[n_iss] = int'(k_idx);
        n_iss++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    n_checks++;
    if (dr_cnt != 1 || lcf_cnt != 1 || lcf_dr != 1) begin
      n_fail++;
      $display("FAIL kgrp_layer_flag got dr=%0d lcf=%0d together=%0d exp 1 1 1", dr_cnt, lcf_cnt, lcf_dr);
    end
    n_checks++;
    if (kc_cnt != 2 || kc_bad != 0) begin
      n_fail++;
      $display("FAIL kgrp_k_changing got pulses=%0d unstalled=%0d exp 2 0", kc_cnt, kc_bad);
    end
    n_checks++;
    if (n_iss != 6) begin
      n_fail++;
      $display("FAIL kgrp_issue_count got=%0d exp=6", n_iss);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (kseq[i] != kexp[i]) begin
          n_fail++;
          $display("FAIL kgrp_k_idx issue=%0d got=%0d exp=%0d", i + 1, kseq[i], kexp[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 10) begin
      n_fail++;
      $display("FAIL kgrp_done got count=%0d cycle=%0d exp 1 10", done_cnt, done_cyc);
    end
  endtask

  // A=2 W=2 K=1; xbar low cycles 3-5 (second issue) and 7-8 (first issue of act 1)
  task automatic test_stall();
    logic [4:0] exp_tab[2:10];
    exp_tab[2]  = 5'b00100; exp_tab[3]  = 5'b10010; exp_tab[4]  = 5'b10010;
    exp_tab[5]  = 5'b10010; exp_tab[6]  = 5'b01010; exp_tab[7]  = 5'b10101;
    exp_tab[8]  = 5'b10101; exp_tab[9]  = 5'b00101; exp_tab[10] = 5'b01011;
    tick();
    arm(2, 2, 1, 1'b0);
    tick();
    start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      tick();
      xbar_ready = !(cyc inside {3, 4, 5, 7, 8});
      #1;
      n_checks++;
      if ({stall, next_a, first_Ex_state_cycle, wgt_idx, act_idx} !==
          {exp_tab[cyc][4:2], 15'd0, exp_tab[cyc][1], 15'd0, exp_tab[cyc][0]}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d got s/na/f=%b w=%0d a=%0d exp s/na/f=%b w=%0d a=%0d", cyc,
                 {stall, next_a, first_Ex_state_cycle}, wgt_idx, act_idx, exp_tab[cyc][4:2], exp_tab[cyc][1], exp_tab[cyc][0]);
      end
    end
    tick();
    xbar_ready = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done_cycle11 got=%b exp=1", done);
    end
    tick();
    #1;
`ifdef MULT_SEQ_PERF_EN
    n_checks++;
    if (stall_cycles !== 32'd5 || issue_cycles !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_counters got stall=%0d issue=%0d exp 5 4", stall_cycles, issue_cycles);
    end
`endif
  endtask

  task automatic test_zero_count();
    tick();
    arm(3, 0, 2, 1'b1);
    tick();
    start = 1'b0;
    #1;
    n_checks++;
    if ({done, decode_restart, busy, stall, Layer_change_flag} !== 5'b10110) begin
      n_fail++;
      $display("FAIL zero_done got=%b exp=10110", {done, decode_restart, busy, stall, Layer_change_flag});
    end
    tick();
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_back_idle got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  // A=4 W=4 K=2, flush on the 5th issue, then idle flush+start, then full tile
  task automatic test_flush();
    int n_iss = 0, done_cnt = 0, done_cyc = -1, kc_cnt = 0;
    tick();
    arm(4, 4, 2, 1'b0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 6) flush = 1'b1;
      #1;
    end
    n_checks++;
    if (act_idx !== 16'd1 || wgt_idx !== 16'd0 || next_a !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_at_issue5 got a=%0d w=%0d na=%b exp 1 0 0", act_idx, wgt_idx, next_a);
    end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {act_idx, wgt_idx, k_idx} !== 40'd0) begin
      n_fail++;
      $display("FAIL flush_idle got busy=%b done=%b idx=%h exp 0 0 0", busy, done, {act_idx, wgt_idx, k_idx});
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      #1;
      if (done) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL flush_no_done got=%0d exp=0", done_cnt);
    end
    arm(4, 4, 2, 1'b0);
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || decode_restart !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_start got busy=%b dr=%b exp 0 0", busy, decode_restart);
    end
    tick();
    arm(4, 4, 2, 1'b0);
    for (int cyc = 1; cyc <= 45; cyc++) begin
      tick();
      start = 1'b0;
      #1;
      if (busy && !stall) n_iss++;
      if (K_changing) kc_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    n_checks++;
    if (n_iss != 32 || kc_cnt != 1 || done_cnt != 1 || done_cyc != 35) begin
      n_fail++;
      $display("FAIL flush_rerun got issues=%0d kchg=%0d done=%0d at %0d exp 32 1 1 35", n_iss, kc_cnt, done_cnt, done_cyc);
    end
  endtask

  // A=1 W=3 K=1; a second start with other counts arrives mid-tile
  task automatic test_busy_start();
    int n_iss = 0, done_cnt = 0, done_cyc = -1;
    tick();
    arm(1, 3, 1, 1'b0);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 2) arm(3, 5, 2, 1'b1);
      #1;
      if (busy && !stall) n_iss++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    n_checks++;
    if (n_iss != 3 || done_cnt != 1 || done_cyc != 5) begin
      n_fail++;
      $display("FAIL busy_start_ignored got issues=%0d done=%0d at %0d exp 3 1 5", n_iss, done_cnt, done_cyc);
    end
  endtask

  task automatic test_async_reset();
    tick();
    arm(2, 2, 2, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b1 || stall !== 1'b0 || wgt_idx !== 16'd1) begin
      n_fail++;
      $display("FAIL areset_pre got busy=%b stall=%b w=%0d exp 1 0 1", busy, stall, wgt_idx);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1 || busy !== 1'b0 || {act_idx, wgt_idx, k_idx} !== 40'd0) begin
      n_fail++;
      $display("FAIL areset_immediate got stall=%b busy=%b idx=%h exp 1 0 0", stall, busy, {act_idx, wgt_idx, k_idx});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; new_layer = 1'b0; flush = 1'b0;
    num_act_vec = '0; num_wgt_vec = '0; num_k_grp = '0;
    iaram_valid = 1'b1; weight_valid = 1'b1; xbar_ready = 1'b1;
    test_reset();
    test_basic();
    test_kgroups();
    test_stall();
    test_zero_count();
    test_flush();
    test_busy_start();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/mult_coord_sequencer.md
Name: mult_coord_sequencer

Overview:
- Sequences the multiplier-array / coordinate-computation datapath (Mult_Coord) through one PE tile's Cartesian-product work.
- Loop order: K group (outer), activation vector (middle), weight vector (inner); activation held stationary while weight vectors stream past it.
- Generates stall, next_a, first_Ex_state_cycle, decode_restart, K_changing and Layer_change_flag.
- Applies crossbar backpressure and operand-fetch readiness; reports progress and completion to the PE controller.

Parameters:
- CNT_W, 16, width of all count inputs and index outputs.
- KG_W, 8, width of K-group count and index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a tile; honoured only in IDLE.
- new_layer  in  1  sampled with start; tile is first of a new layer.
- flush  in  1  synchronous abort.
- num_act_vec  in  CNT_W  activation vectors per K group; sampled with start.
- num_wgt_vec  in  CNT_W  weight vectors per activation vector; sampled with start.
- num_k_grp  in  KG_W  K groups; sampled with start.
- iaram_valid  in  1  activation operand vector ready.
- weight_valid  in  1  weight operand vector ready.
- xbar_ready  in  1  downstream crossbar can accept products.
- stall  out  1  datapath hold.
- next_a  out  1  advance activation vector.
- first_Ex_state_cycle  out  1  first issue of an activation vector.
- decode_restart  out  1  restart index decoders.
- Layer_change_flag  out  1  new-layer indication to coordinate logic.
- K_changing  out  1  K-group boundary.
- act_idx  out  CNT_W  current activation vector index.
- wgt_idx  out  CNT_W  current weight vector index.
- k_idx  out  KG_W  current K group.
- busy  out  1  not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE; all indices 0. All outputs 0, except stall=1 (datapath held while idle).
- States: IDLE, LOAD, EXEC, KCHG, DONE. State and counters are registered.
- IDLE:
  - stall=1.
  - start=1 latches the three counts and new_layer, then goes to LOAD.
  - If any latched count is 0, go to DONE instead.
- LOAD (1 cycle):
  - decode_restart=1; Layer_change_flag=1 if new_layer was latched.
  - Indices cleared; first flag set; next state EXEC.
- EXEC:
  - issue = xbar_ready & iaram_valid & weight_valid (combinational).
  - stall = ~issue.
  - first_Ex_state_cycle = first flag; the flag clears on the first issue, so it stays high through stalls.
  - On issue with wgt_idx < num_wgt_vec-1: wgt_idx++.
  - On issue with wgt_idx == num_wgt_vec-1: next_a=1 (same cycle, combinational); wgt_idx=0; first flag set.
    - If act_idx < num_act_vec-1: act_idx++, stay in EXEC.
    - Else if k_idx < num_k_grp-1: go to KCHG.
    - Else: go to DONE.
  - next_a is never asserted while stall=1.
- KCHG (1 cycle):
  - K_changing=1, stall=1.
  - k_idx++, act_idx=0; return to EXEC with first flag set.
- DONE (1 cycle): done=1, stall=1, indices held; next state IDLE.
- Throughput and latency:
  - Without stalls, total issue cycles = A*W*K.
  - Done appears 2 + A*W*K + (K-1) cycles after start, counting LOAD and KCHG cycles.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored; counts are not re-sampled mid-tile.
- flush in any state except IDLE: next state IDLE, indices cleared, no done pulse. flush beats issue when both occur in the same cycle.
- flush in IDLE with start: flush wins and start is dropped.
- Single-element tile (counts 1,1,1): one EXEC issue cycle, with first_Ex_state_cycle=1 and next_a=1 in that same cycle.
- Counter compares are unsigned; indices never exceed count-1.

Optional Feature:
- Macro: MULT_SEQ_PERF_EN.
- Defined: adds outputs stall_cycles (32-bit) and issue_cycles (32-bit).
  - stall_cycles counts EXEC cycles with stall=1; issue_cycles counts EXEC cycles with an issue.
  - Both clear in LOAD, saturate at all-ones, and are held after DONE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- A=2, W=3, K=1, operands always ready, xbar_ready=1 → decode_restart in cycle 1; 6 issue cycles; next_a in issue cycles 3 and 6; first_Ex_state_cycle in issue cycles 1 and 4; done 8 cycles after start.
- A=1, W=2, K=3, new_layer=1 → Layer_change_flag=1 together with decode_restart; K_changing pulses twice; k_idx walks 0,1,2; done once.
- A=2, W=2, K=1, xbar_ready low for 3 cycles on the second issue → stall=1 for exactly those cycles; wgt_idx and act_idx frozen; first_Ex_state_cycle held through the stall; next_a never asserted during the stall.
- num_wgt_vec=0 with start → IDLE→DONE→IDLE; done one cycle; no decode_restart; no issue.
- A=4, W=4, K=2 with flush at the 5th issue cycle → next state IDLE, no done, indices 0. A subsequent start runs the full tile normally.
- Async rst asserted mid-EXEC between clock edges → outputs immediately reset (stall=1, busy=0); second start during busy is ignored. With MULT_SEQ_PERF_EN, a run with 3 stall cycles reports stall_cycles=3 and issue_cycles=A*W*K.
